// File: rtl/turbo_enc_pkg.sv
// Shared types and constants for the turbo encoder lane control logic.
package turbo_enc_pkg;
  localparam int unsigned MIN_BYTES  = 5;
  localparam int unsigned MAX_BYTES  = 768;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned TAIL_BYTES = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DATA,
    CAPTURE,
    TAIL,
    DONE
  } state_t;
endpackage

// File: rtl/turbo_byte_counter.sv
// Byte counter with latched block size and terminal-count compare (count == size-1).
module turbo_byte_counter #(
  parameter int unsigned CNT_W = turbo_enc_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] size_in,
  input  logic             clear,
  input  logic             enable,
  output logic             terminal
);
  logic [CNT_W-1:0] size_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      size_q  <= '0;
      count_q <= '0;
    end else begin
      if (load) size_q <= size_in;
      if (clear)       count_q <= '0;
      else if (enable) count_q <= count_q + CNT_W'(1);
    end
  end

  assign terminal = (count_q == size_q - CNT_W'(1));
endmodule

// File: rtl/turbo_tail_sequencer.sv
// Block sequencer for one 8-bit turbo encoder lane: clear, data bytes, trellis
// capture, one tail byte, done.
module turbo_tail_sequencer #(
  parameter int unsigned MAX_BYTES = turbo_enc_pkg::MAX_BYTES,
  parameter int unsigned MIN_BYTES = turbo_enc_pkg::MIN_BYTES,
  parameter int unsigned CNT_W     = turbo_enc_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] block_bytes,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_last,
  output logic             enc_clear,
  output logic             enc_enable,
  output logic             tail_bit_regs_enable,
  output logic             tail_bit_mode,
  output logic             busy,
  output logic             done,
  output logic             err_size
);
  import turbo_enc_pkg::*;

  localparam logic [CNT_W-1:0] MIN_SZ = CNT_W'(MIN_BYTES);
  localparam logic [CNT_W-1:0] MAX_SZ = CNT_W'(MAX_BYTES);

  state_t state, state_nx;
  logic   err_q;
  logic   size_ok, start_ok, xfer, terminal;

  assign size_ok  = (block_bytes >= MIN_SZ) && (block_bytes <= MAX_SZ);
  assign start_ok = (state == IDLE) && start && size_ok;
  assign xfer     = (state == DATA) && in_valid && out_ready;

  turbo_byte_counter #(.CNT_W(CNT_W)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (start_ok),
    .size_in  (block_bytes),
    .clear    (start_ok || (xfer && terminal)),
    .enable   (xfer),
    .terminal (terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= (state == IDLE) && start && !size_ok;
    end
  end

  always_comb begin
    state_nx             = state;
    in_ready             = 1'b0;
    out_valid            = 1'b0;
    out_last             = 1'b0;
    enc_clear            = 1'b0;
    enc_enable           = 1'b0;
    tail_bit_regs_enable = 1'b0;
    tail_bit_mode        = 1'b0;
    busy                 = (state != IDLE);
    done                 = 1'b0;
    err_size             = err_q;
    case (state)
      IDLE:    if (start_ok) state_nx = CLEAR;
      CLEAR: begin
        enc_clear = 1'b1;
        state_nx  = DATA;
      end
      DATA: begin
        in_ready   = out_ready;
        out_valid  = in_valid;
        enc_enable = xfer;
        if (xfer && terminal) state_nx = CAPTURE;
      end
      CAPTURE: begin
        tail_bit_regs_enable = 1'b1;
        state_nx             = TAIL;
      end
      TAIL: begin
        tail_bit_mode = 1'b1;
        out_valid     = 1'b1;
        out_last      = 1'b1;
        if (out_ready) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: doc/turbo_tail_sequencer.md
Name: turbo_tail_sequencer

Overview:
Control FSM for one 8-bit-parallel turbo encoder lane. It sequences each code block through trellis clear, K/8 data bytes, trellis-state capture and one tail-byte output, and drives the tail bit generator's register-enable and mode-select inputs. It sits between the upstream byte source and the downstream rate-matching/interleaver buffer, and owns the valid/ready handshakes on both sides.

Parameters:
MAX_BYTES, 768, largest block in bytes (K=6144)
MIN_BYTES, 5, smallest block in bytes (K=40)
CNT_W, 10, byte counter / block_bytes width

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to encode a block; sampled only in IDLE
block_bytes  input  CNT_W  block length in bytes (K/8), sampled with start
in_valid  input  1  upstream data byte available
in_ready  output  1  byte accepted when in_valid && in_ready
out_ready  input  1  downstream can take an encoder output byte
out_valid  output  1  encoder output (xk/zk/zk') valid this cycle
out_last  output  1  marks the tail byte, the final output of the block
enc_clear  output  1  clears encoder constituent shift registers to zero
enc_enable  output  1  advances encoder trellis by one byte
tail_bit_regs_enable  output  1  captures q0..q2 / q0'..q2' into the tail registers
tail_bit_mode  output  1  selects tail bits onto the encoder output muxes
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the tail byte is taken
err_size  output  1  one-cycle pulse when start carries an illegal block_bytes

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0, latched size=0. All outputs read 0.
- States: IDLE, CLEAR, DATA, CAPTURE, TAIL, DONE. State encoding is one register. enc_clear, tail_bit_regs_enable, tail_bit_mode, out_last, busy, done and err_size are Moore-decoded from registered state or flags. in_ready, out_valid and enc_enable are combinational in DATA/TAIL only.
- IDLE: if start and MIN_BYTES<=block_bytes<=MAX_BYTES, latch size, counter<=0, go to CLEAR. If start with an illegal size, err_size=1 next cycle and stay in IDLE. start outside IDLE is ignored (no latch, no error).
- CLEAR: enc_clear=1 for exactly one cycle, then DATA.
- DATA: in_ready=out_ready; out_valid=in_valid; enc_enable=in_valid&&out_ready. On each transfer counter++. On a transfer with counter==size-1, go to CAPTURE and clear the counter. No transfer means hold; no bubble is inserted between back-to-back transfers.
- CAPTURE: in_ready=0, out_valid=0, tail_bit_regs_enable=1 for one cycle. Encoder q state at this cycle is the post-final-byte state. Then TAIL.
- TAIL: tail_bit_mode=1, out_valid=1, out_last=1, enc_enable=0. Hold until out_ready, then DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE. A start in this cycle is ignored.
- tail_bit_mode must be 0 in every state except TAIL, so data bytes are never corrupted. tail_bit_regs_enable is asserted exactly once per block.
- Counter never wraps: max value is size-1 <= 767 < 2^CNT_W.
- Throughput: size+4 cycles per block with no backpressure (start cycle excluded).

Decomposition:
- Shared package turbo_enc_pkg holds:
  - state enum (IDLE, CLEAR, DATA, CAPTURE, TAIL, DONE)
  - MIN_BYTES and MAX_BYTES constants
  - CNT_W constant
  - TAIL_BYTES=1 constant
- One natural sub-module, turbo_byte_counter: a loadable up-counter with clear, enable and terminal-count compare against the latched size. The FSM stays in the top module.

Test Plan:
- Size 5, in_valid=1, out_ready=1, start at cycle 0 -> enc_clear at cycle 1; in_ready/enc_enable/out_valid at cycles 2–6 (5 transfers); tail_bit_regs_enable at cycle 7; tail_bit_mode+out_valid+out_last at cycle 8; done at cycle 9; busy deasserted at cycle 10.
- Size 768 with random in_valid and out_ready at 50% each -> exactly 768 enc_enable pulses, one capture, one tail byte, and no tail_bit_mode outside TAIL.
- out_ready=0 held for 3 cycles in TAIL -> out_valid/out_last/tail_bit_mode stay high, no done; done pulses one cycle after out_ready rises.
- start with block_bytes=4, then 769 -> err_size pulse each, busy stays 0, no enc_clear.
- start pulsed during DATA and during DONE -> ignored, byte count unchanged. Reset asserted after 3 of 10 bytes -> all outputs 0 immediately; a new start then runs a full 10-byte block.
- Back-to-back blocks (sizes 6 then 5), start issued the cycle after done -> second enc_clear occurs and the counter restarts at 0.
